// File: rtl/imm_gen_if.sv
// Valid/ready stream bundle for the immediate generator: instruction in, decoded immediate out.
// slave is the generator's view, master is the fetch/consumer side.
interface imm_gen_if #(
  parameter int XLEN  = 64,
  parameter int FMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [FMT_W-1:0] out_fmt;
  logic [31:0]      out_instr;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_instr
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_instr
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer (head + skid registers).
// Optional macro IMM_GEN_CSR_EN enables the CSR-immediate format (CSRR*I zimm).
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int FMT_W = 3
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  imm_gen_if.slave   bus
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [FMT_W-1:0] FMT_NONE = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I    = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S    = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B    = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U    = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J    = FMT_W'(5);
`ifdef IMM_GEN_CSR_EN
  localparam logic [FMT_W-1:0] FMT_CSR  = FMT_W'(6);
`endif

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e             state, state_nxt;
  logic             in_ready_q;
  logic             out_valid;
  logic             push, pop;
  logic             load_head, load_skid, head_from_skid;

  logic [63:0]      imm64;
  logic [XLEN-1:0]  dec_imm;
  logic [FMT_W-1:0] dec_fmt;

  logic [XLEN-1:0]  head_imm,   skid_imm;
  logic [FMT_W-1:0] head_fmt,   skid_fmt;
  logic [31:0]      head_instr, skid_instr;

  // Decode is built at 64 bits and truncated, so XLEN=32 needs no zero-width replication.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    imm64   = '0;
    dec_fmt = FMT_NONE;
    case (bus.in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm64   = {{52{bus.in_instr[31]}}, bus.in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          imm64   = {{52{bus.in_instr[31]}}, bus.in_instr[31:20]};
          dec_fmt = FMT_I;
        end
      end
      7'b0100011: begin
        imm64   = {{52{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        imm64   = {{51{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                   bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm64   = {{32{bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        imm64   = {{43{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        if (bus.in_instr[14]) begin
          imm64   = {59'b0, bus.in_instr[19:15]};
          dec_fmt = FMT_CSR;
        end
      end
`endif
      default: ;
    endcase
  end

  assign dec_imm   = imm64[XLEN-1:0];
  assign out_valid = (state != EMPTY);
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Datapath steering: a push lands in head when head is free (or leaving), else in skid.
  always_comb begin
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: load_head = push;
        ONE: begin
          load_head = push && pop;
          load_skid = push && !pop;
        end
        TWO:     head_from_skid = pop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_imm   <= '0;
      head_fmt   <= FMT_NONE;
      head_instr <= '0;
    end else if (load_head) begin
      head_imm   <= dec_imm;
      head_fmt   <= dec_fmt;
      head_instr <= bus.in_instr;
    end else if (head_from_skid) begin
      head_imm   <= skid_imm;
      head_fmt   <= skid_fmt;
      head_instr <= skid_instr;
    end
  end

  // NOTE: skid storage is not reset; it is only read after being written while state is TWO.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_instr <= bus.in_instr;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_imm   = head_imm;
  assign bus.out_fmt   = head_fmt;
  assign bus.out_instr = head_instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=64): directed steps with a scoreboard queue.
// Honours IMM_GEN_CSR_EN for the expected CSR-immediate result.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  exp_t q[$];

  imm_gen_if #(.XLEN(64), .FMT_W(3)) bus ();

  imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder for RV64 written from the instruction-format tables.
  function automatic void model(input logic [31:0] i, output logic [63:0] imm,
                                output logic [2:0] fmt);
    logic signed [63:0] v;
    v   = '0;
    fmt = 3'd0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B: begin v = $signed(i[31:20]); fmt = 3'd1; end
      7'h23: begin v = $signed({i[31:25], i[11:7]}); fmt = 3'd2; end
      7'h63: begin v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); fmt = 3'd3; end
      7'h37, 7'h17: begin v = $signed({i[31:12], 12'h000}); fmt = 3'd4; end
      7'h6F: begin v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); fmt = 3'd5; end
`ifdef IMM_GEN_CSR_EN
      7'h73: if (i[14]) begin v = {59'b0, i[19:15]}; fmt = 3'd6; end
`endif
      default: ;
    endcase
    imm = v;
  endfunction

  // One clock of stimulus; checks handshake state and scoreboard before the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                      input logic [63:0] eimm, input logic [2:0] efmt);
    exp_t e;
    bit   can_push;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    can_push = (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) begin
        e = q.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check("out_imm", bus.out_imm, e.imm);
        check("out_fmt", bus.out_fmt, e.fmt);
      end
      if (v && can_push) begin
        e.instr = ins;
        e.imm   = eimm;
        e.fmt   = efmt;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_m(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic [63:0] mi;
    logic [2:0]  mf;
    model(ins, mi, mf);
    step(v, ins, ordy, fl, mi, mf);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  ops [10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_imm", bus.out_imm, 64'h0);
    check("rst_out_fmt", bus.out_fmt, 3'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    rst = 1'b0;

    // addi x1,x0,-1, then idle: out_imm must hold after the pop.
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 3'd0);
    check("hold_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // beq -4 and lui 0x80000 streaming back to back.
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    step(1'b1, 32'h800000B7, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4);
    step(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 3'd0);

    // Back-pressure: A and B accepted, C held until space frees.
    step_m(1'b1, 32'hFE112C23, 1'b0, 1'b0);
    step_m(1'b1, 32'hFF9FF06F, 1'b0, 1'b0);
    step_m(1'b1, 32'h0010809B, 1'b0, 1'b0);
    step_m(1'b1, 32'h0010809B, 1'b1, 1'b0);
    step_m(1'b1, 32'h0010809B, 1'b1, 1'b0);
    step_m(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a same-cycle push; nothing may come out afterwards.
    step_m(1'b1, 32'h12345017, 1'b0, 1'b0);
    step_m(1'b1, 32'h7FF00013, 1'b0, 1'b0);
    step_m(1'b1, 32'hABCDE037, 1'b1, 1'b1);
    step_m(1'b0, 32'h0, 1'b1, 1'b0);
    step_m(1'b0, 32'h0, 1'b1, 1'b0);

    // csrrwi x0,0x300,31 and a csrrw (funct3[2]=0), then an unknown opcode.
`ifdef IMM_GEN_CSR_EN
    step(1'b1, 32'h300FD073, 1'b1, 1'b0, 64'd31, 3'd6);
`else
    step(1'b1, 32'h300FD073, 1'b1, 1'b0, 64'd0, 3'd0);
`endif
    step(1'b1, 32'h300F9073, 1'b1, 1'b0, 64'd0, 3'd0);
    step_m(1'b1, 32'hFFFFF033, 1'b1, 1'b0);

    // Random mix of formats with random back-pressure.
    for (int k = 0; k < 40; k++) begin
      r      = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      step_m(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Drain, bounded.
    for (int k = 0; k < 4; k++) step_m(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
